// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues ex/mem loads/stores as req/ack transactions,
// stalls the pipeline until they complete, holds load data, and flags illegal/timeout accesses.
// Ports:
//   clk, rst (async active-low)
//   ex/mem side:   valid_m, MemRead_m, MemWrite_m, addr_m, wdata_m
//   mem/wb side:   nop_w (downstream hold), memResult_m
//   memory side:   mem_req, mem_wr, mem_addr, mem_wdata, mem_ack, mem_rdata
//   pipeline side: stall_m, err_m (sticky until reset)
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        MemRead_m,
  input  logic        MemWrite_m,
  input  logic [15:0] addr_m,
  input  logic [15:0] wdata_m,
  input  logic        nop_w,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] memResult_m,
  output logic        stall_m,
  output logic        err_m
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic       access;
  logic       illegal;
  logic       stall;

  assign access  = valid_m & (MemRead_m | MemWrite_m);
  assign illegal = access &
                   (addr_m[0] | (MemRead_m & MemWrite_m));

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          state_n = illegal ? ERR : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack)
          state_n = DONE;
        else if (cnt == CNT_LAST)
          state_n = ERR;
      end
      DONE: begin
        if (!nop_w)
          state_n = IDLE;
      end
      ERR: begin
        stall = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 16'h0000;
      memResult_m <= 16'h0000;
    end else begin
      state   <= state_n;
      mem_req <= (state_n == BUSY);
      if (state == IDLE && access && !illegal) begin
        mem_addr  <= addr_m;
        mem_wdata <= wdata_m;
        mem_wr    <= MemWrite_m;
        cnt       <= 8'd0;
      end
      if (state == BUSY) begin
        if (mem_ack) begin
          cnt <= 8'd0;
          if (!mem_wr)
            memResult_m <= mem_rdata;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  // Gated by rst so every output reads 0 while reset is held,
  // even if ex/mem presents an access at that moment.
  assign stall_m = stall & rst;
  assign err_m   = (state == ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table-driven load/store/hold vectors
// plus directed reset, illegal-address and timeout sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m;
  logic        MemRead_m;
  logic        MemWrite_m;
  logic [15:0] addr_m;
  logic [15:0] wdata_m;
  logic        nop_w;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] memResult_m;
  logic        stall_m;
  logic        err_m;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .valid_m(valid_m),
    .MemRead_m(MemRead_m),
    .MemWrite_m(MemWrite_m),
    .addr_m(addr_m),
    .wdata_m(wdata_m),
    .nop_w(nop_w),
    .mem_req(mem_req),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .memResult_m(memResult_m),
    .stall_m(stall_m),
    .err_m(err_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        nop;
    logic        ack;
    logic [15:0] rdata;
    logic        req;
    logic        mwr;
    logic        stall;
    logic        err;
    logic [15:0] maddr;
    logic [15:0] mwdata;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r,
                       input logic w,
                       input logic [15:0] a,
                       input logic [15:0] d,
                       input logic n, input logic k,
                       input logic [15:0] rd);
    valid_m    = v;
    MemRead_m  = r;
    MemWrite_m = w;
    addr_m     = a;
    wdata_m    = d;
    nop_w      = n;
    mem_ack    = k;
    mem_rdata  = rd;
  endtask

  task automatic chk_ctl(input string tag,
                         input logic req,
                         input logic stall,
                         input logic err);
    chk({tag, ".req"}, {15'd0, mem_req}, {15'd0, req});
    chk({tag, ".stall"}, {15'd0, stall_m},
        {15'd0, stall});
    chk({tag, ".err"}, {15'd0, err_m}, {15'd0, err});
  endtask

  task automatic chk_zero(input string tag);
    chk_ctl(tag, 1'b0, 1'b0, 1'b0);
    chk({tag, ".wr"}, {15'd0, mem_wr}, 16'h0);
    chk({tag, ".addr"}, mem_addr, 16'h0);
    chk({tag, ".wdata"}, mem_wdata, 16'h0);
    chk({tag, ".res"}, memResult_m, 16'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Load 0x10, ack in 3rd req cycle; valid drops mid-BUSY
    vecs[0]  = '{1,1,0,16'h0010,16'h0,0,0,16'h0,
                 0,0,1,0,16'h0010,16'h0,16'h0000};
    vecs[1]  = '{1,1,0,16'h0010,16'h0,0,0,16'h0,
                 1,0,1,0,16'h0010,16'h0,16'h0000};
    vecs[2]  = '{0,0,0,16'h0000,16'h0,0,0,16'h0,
                 1,0,1,0,16'h0010,16'h0,16'h0000};
    vecs[3]  = '{1,1,0,16'h0010,16'h0,0,1,16'hBEEF,
                 1,0,1,0,16'h0010,16'h0,16'h0000};
    vecs[4]  = '{1,1,0,16'h0010,16'h0,0,0,16'h0,
                 0,0,0,0,16'h0,16'h0,16'hBEEF};
    // Store 0x20 <- 0x1234, ack in first req cycle
    vecs[5]  = '{1,0,1,16'h0020,16'h1234,0,0,16'h0,
                 0,0,1,0,16'h0,16'h0,16'hBEEF};
    vecs[6]  = '{1,0,1,16'h0020,16'h1234,0,1,16'hDEAD,
                 1,1,1,0,16'h0020,16'h1234,16'hBEEF};
    vecs[7]  = '{1,0,1,16'h0020,16'h1234,0,0,16'h0,
                 0,0,0,0,16'h0,16'h0,16'hBEEF};
    // Load 0x30, then held in DONE by nop_w for 4 cycles
    vecs[8]  = '{1,1,0,16'h0030,16'h0,0,0,16'h0,
                 0,0,1,0,16'h0,16'h0,16'hBEEF};
    vecs[9]  = '{1,1,0,16'h0030,16'h0,0,1,16'hA5A5,
                 1,0,1,0,16'h0030,16'h0,16'hBEEF};
    for (int i = 10; i < 14; i++)
      vecs[i] = '{1,1,0,16'h0030,16'h0,1,1,16'hFFFF,
                  0,0,0,0,16'h0,16'h0,16'hA5A5};
    vecs[14] = '{1,1,0,16'h0030,16'h0,0,0,16'h0,
                 0,0,0,0,16'h0,16'h0,16'hA5A5};
    // IDLE right after nop_w falls: new load stalls
    vecs[15] = '{1,1,0,16'h0040,16'h0,0,0,16'h0,
                 0,0,1,0,16'h0,16'h0,16'hA5A5};
    vecs[16] = '{1,1,0,16'h0040,16'h0,0,1,16'h0F0F,
                 1,0,1,0,16'h0040,16'h0,16'hA5A5};
    vecs[17] = '{0,0,0,16'h0000,16'h0,0,0,16'h0,
                 0,0,0,0,16'h0,16'h0,16'h0F0F};
    vecs[18] = '{0,0,0,16'h0000,16'h0,0,0,16'h0,
                 0,0,0,0,16'h0,16'h0,16'h0F0F};

    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr,
            vecs[i].addr, vecs[i].wdata, vecs[i].nop,
            vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      chk_ctl($sformatf("v%0d", i), vecs[i].req,
              vecs[i].stall, vecs[i].err);
      chk($sformatf("v%0d.res", i), memResult_m,
          vecs[i].res);
      if (vecs[i].req) begin
        chk($sformatf("v%0d.maddr", i), mem_addr,
            vecs[i].maddr);
        chk($sformatf("v%0d.mwr", i),
            {15'd0, mem_wr}, {15'd0, vecs[i].mwr});
        if (vecs[i].mwr)
          chk($sformatf("v%0d.mwdata", i), mem_wdata,
              vecs[i].mwdata);
      end
      next_cycle();
    end

    // Reset asserted in BUSY cycle 2 of a load
    drive(1, 1, 0, 16'h0050, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    chk_ctl("rst6.c0", 0, 1, 0);
    next_cycle();
    @(negedge clk);
    chk_ctl("rst6.c1", 1, 1, 0);
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst6.mid");
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    chk_zero("rst6.hold");
    rst = 1'b1;
    next_cycle();
    drive(1, 1, 0, 16'h0060, 16'h0, 0, 1, 16'h00FF);
    @(negedge clk);
    chk_ctl("post6.c0", 0, 1, 0);
    chk("post6.c0.res", memResult_m, 16'h0000);
    next_cycle();
    @(negedge clk);
    chk_ctl("post6.c1", 1, 1, 0);
    chk("post6.c1.addr", mem_addr, 16'h0060);
    next_cycle();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    chk_ctl("post6.c2", 0, 0, 0);
    chk("post6.c2.res", memResult_m, 16'h00FF);
    next_cycle();

    // Odd-address load goes straight to ERR
    drive(1, 1, 0, 16'h0013, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    chk_ctl("odd.c0", 0, 1, 0);
    next_cycle();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h1111);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("odd.c%0d", i), 0, 1, 1);
      chk($sformatf("odd.c%0d.res", i), memResult_m,
          16'h00FF);
      next_cycle();
    end

    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    #1;
    chk_zero("rst4");
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    // Never-acked load times out after 4 BUSY cycles
    drive(1, 1, 0, 16'h0070, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    chk_ctl("to.c0", 0, 1, 0);
    next_cycle();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("to.c%0d", i), 1, 1, 0);
      next_cycle();
    end
    for (int i = 5; i < 7; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("to.c%0d", i), 0, 1, 1);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
